// File: rtl/mem_access_sched_pkg.sv
// Shared constants and types for the memory access scheduler.
package mem_access_sched_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int MEM_LATENCY = 5;

    // Latency counter width; holds MEM_LATENCY-1 for latencies up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_RESP   = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_access_sched_counter.sv
// Loadable down-counter that times one memory access; zero marks the final cycle.
module mem_latency_counter
    import mem_access_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on grant, then count down once per access cycle and park at zero.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_sched.sv
// Arbitrates fetch and load/store requests onto one fixed-latency memory port.
module mem_access_sched #(
    parameter int WORD_SIZE   = mem_access_sched_pkg::WORD_SIZE,
    parameter int MEM_LATENCY = mem_access_sched_pkg::MEM_LATENCY  // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,
    output logic                 stall_i,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 stall_d,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    import mem_access_sched_pkg::*;

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(MEM_LATENCY - 1);

    state_t state, next_state;

    logic                 grant_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    logic take;        // grant made this cycle
    logic grant_side;  // which side wins when take is high
    logic finish;      // final ACCESS cycle
    logic cnt_en;
    logic cnt_zero;

    mem_latency_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (take),
        .load_value (LOAD_VALUE),
        .enable     (cnt_en),
        .zero       (cnt_zero)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and arbitration; the data side wins ties as the older instruction.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        take       = 1'b0;
        grant_side = GRANT_I;
        finish     = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (d_req || i_req) begin
                    take       = 1'b1;
                    grant_side = d_req ? GRANT_D : GRANT_I;
                    next_state = STATE_ACCESS;
                end
            end
            STATE_ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    finish     = 1'b1;
                    next_state = STATE_RESP;
                end
            end
            // Requester still holds req for the completing op, so no grant here.
            STATE_RESP: next_state = STATE_IDLE;
            default:    next_state = STATE_IDLE;
        endcase
    end

    // Latch the granted request so later requester changes cannot disturb the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= GRANT_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            grant_q <= grant_side;
            we_q    <= (grant_side == GRANT_D) && d_we;
            addr_q  <= (grant_side == GRANT_D) ? d_addr : i_addr;
            wdata_q <= (grant_side == GRANT_D) ? d_wdata : '0;
        end
    end

    // Capture read data and raise the granted side's done for the RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
        end else begin
            i_done <= finish && (grant_q == GRANT_I);
            d_done <= finish && (grant_q == GRANT_D);
            if (finish && !we_q) begin
                if (grant_q == GRANT_D) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

    // Port drive decodes straight from registered state; the write strobe is
    // confined to the last cycle so an aborted store never commits.
    assign mem_en    = (state == STATE_ACCESS);
    assign mem_we    = (state == STATE_ACCESS) && cnt_zero && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != STATE_IDLE);

    assign stall_i = i_req & ~i_done;
    assign stall_d = d_req & ~d_done;

endmodule

// File: tb/tb_mem_access_sched.sv
// Directed self-checking bench for mem_access_sched (latency 5, plus a latency-1 build).
module tb_mem_access_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done, stall_i;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done, stall_d;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        l1_i_req = 1'b0;
    logic [31:0] l1_i_addr = '0;
    logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_i_done, l1_stall_i, l1_d_done, l1_stall_d;
    logic        l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0] l1_mem_rdata = '0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_access_sched #(.WORD_SIZE(32), .MEM_LATENCY(5)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .stall_i(stall_i),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .stall_d(stall_d),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_sched #(.WORD_SIZE(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata), .i_done(l1_i_done),
        .stall_i(l1_stall_i),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_rdata(l1_d_rdata),
        .d_done(l1_d_done), .stall_d(l1_stall_d),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sample one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic check_cycle(input string tag, input logic en, input logic we,
                               input logic id, input logic dd, input logic si,
                               input logic sd, input logic chk_addr,
                               input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        check({tag, "_mem_en"},  32'(mem_en),  32'(en));
        check({tag, "_mem_we"},  32'(mem_we),  32'(we));
        check({tag, "_i_done"},  32'(i_done),  32'(id));
        check({tag, "_d_done"},  32'(d_done),  32'(dd));
        check({tag, "_stall_i"}, 32'(stall_i), 32'(si));
        check({tag, "_stall_d"}, 32'(stall_d), 32'(sd));
        check({tag, "_busy"},    32'(busy),    32'(en | id | dd));
        if (chk_addr) begin
            check({tag, "_mem_addr"},  mem_addr,  addr);
            check({tag, "_mem_wdata"}, mem_wdata, wdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic en;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_i_done", 32'(i_done), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_l1_busy", 32'(l1_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single load at 0x10
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'h0;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) d_req = 1'b0;
            mem_rdata = (c == 5) ? 32'hDEADBEEF : 32'hBAD0BAD0;
            en = (c >= 1 && c <= 5);
            check_cycle($sformatf("t1_c%0d", c), en, 1'b0, 1'b0, (c == 6), 1'b0, (c <= 5),
                        en, 32'h10, 32'h0);
        end
        check("t1_d_rdata", d_rdata, 32'hDEADBEEF);

        // 2: store at 0x20
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) d_req = 1'b0;
            mem_rdata = 32'hFFFF0000;
            en = (c >= 1 && c <= 5);
            check_cycle($sformatf("t2_c%0d", c), en, (c == 5), 1'b0, (c == 6), 1'b0, (c <= 5),
                        en, 32'h20, 32'h12345678);
        end
        check("t2_d_rdata_kept", d_rdata, 32'hDEADBEEF);

        // 3: simultaneous fetch and load, data side first
        d_we = 1'b0; d_wdata = 32'h0; d_addr = 32'h80; d_req = 1'b1;
        i_addr = 32'h40; i_req = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            if (c == 7) d_req = 1'b0;
            if (c == 14) i_req = 1'b0;
            mem_rdata = (c == 5) ? 32'hD0D0D0D0 : (c == 12) ? 32'h1A1A1A1A : 32'hBAD0BAD0;
            en = (c >= 1 && c <= 5) || (c >= 8 && c <= 12);
            check_cycle($sformatf("t3_c%0d", c), en, 1'b0, (c == 13), (c == 6), (c <= 12),
                        (c <= 5), en, (c <= 5) ? 32'h80 : 32'h40, 32'h0);
        end
        check("t3_d_rdata", d_rdata, 32'hD0D0D0D0);
        check("t3_i_rdata", i_rdata, 32'h1A1A1A1A);

        // 4: back-to-back fetches with i_req held
        i_req = 1'b1; i_addr = 32'h100;
        for (int c = 0; c <= 21; c++) begin
            if (c == 21) i_req = 1'b0;
            else if (c % 7 == 0) i_addr = 32'h100 + 32'(4 * (c / 7));
            mem_rdata = (c % 7 == 5) ? 32'hA000 + 32'(c / 7) : 32'hBAD0BAD0;
            en = (c < 21) && (c % 7 >= 1) && (c % 7 <= 5);
            check_cycle($sformatf("t4_c%0d", c), en, 1'b0, (c % 7 == 6), 1'b0,
                        (c < 21) && (c % 7 != 6), 1'b0, en, 32'h100 + 32'(4 * (c / 7)), 32'h0);
            if (c % 7 == 6) check($sformatf("t4_c%0d_i_rdata", c), i_rdata, 32'hA000 + 32'(c / 7));
        end

        // 5: reset pulsed in cycle 3 of a store, then the store is re-issued
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h55AA;
        for (int c = 0; c <= 11; c++) begin
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            if (c == 11) d_req = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            en = (c >= 1 && c <= 2) || (c >= 5 && c <= 9);
            check_cycle($sformatf("t5_c%0d", c), en, (c == 9), 1'b0, (c == 10), 1'b0, (c <= 9),
                        en || (c == 3), (c == 3) ? 32'h0 : 32'h30,
                        (c == 3) ? 32'h0 : 32'h55AA);
        end
        check("t5_d_rdata", d_rdata, 32'h0);
        check("t5_i_rdata", i_rdata, 32'h0);

        // 6: latency-1 build, single fetch
        l1_i_req = 1'b1; l1_i_addr = 32'h44;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) l1_i_req = 1'b0;
            l1_mem_rdata = (c == 1) ? 32'hCAFE0001 : 32'hBAD0BAD0;
            @(negedge clk);
            check($sformatf("t6_c%0d_mem_en", c), 32'(l1_mem_en), 32'(c == 1));
            check($sformatf("t6_c%0d_i_done", c), 32'(l1_i_done), 32'(c == 2));
            check($sformatf("t6_c%0d_stall_i", c), 32'(l1_stall_i), 32'(c <= 1));
            check($sformatf("t6_c%0d_busy", c), 32'(l1_busy), 32'(c == 1 || c == 2));
            if (c == 1) check("t6_mem_addr", l1_mem_addr, 32'h44);
            @(posedge clk);
            #1;
        end
        check("t6_i_rdata", l1_i_rdata, 32'hCAFE0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
